// File: rtl/div_job_dispatcher.sv
// Upstream feeder for the serial single-precision divider: queues tagged operand
// pairs, runs one job at a time through the a/b/z handshakes, returns tagged results.
module div_job_dispatcher #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CYC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             job_a,
    input  logic [31:0]             job_b,
    input  logic [TAG_W-1:0]        job_tag,
    input  logic                    job_stb,
    output logic                    job_ack,
    output logic [31:0]             div_a,
    output logic                    div_a_stb,
    input  logic                    div_a_ack,
    output logic [31:0]             div_b,
    output logic                    div_b_stb,
    input  logic                    div_b_ack,
    input  logic [31:0]             div_z,
    input  logic                    div_z_stb,
    output logic                    div_z_ack,
    output logic [31:0]             res_z,
    output logic [TAG_W-1:0]        res_tag,
    output logic [CYC_W-1:0]        res_cycles,
    output logic                    res_stb,
    input  logic                    res_ack,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [2:0]              fsm_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TAG_W + 64;
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    // Every channel transfers on a clk edge where stb && ack are both 1; the
    // producer holds stb and data stable until that edge and drops stb on it.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_A  = 3'd1,
        SEND_B  = 3'd2,
        WAIT_Z  = 3'd3,
        PUT_RES = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ENT_W-1:0] head;

    logic push;
    logic pop;
    logic z_done;
    logic counting;

    logic [TAG_W-1:0] tag_q;
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_inc;

    assign job_ack    = (count != CNT_W'(DEPTH));
    assign push       = job_stb && job_ack;
    assign pop        = (state == IDLE) && (count != '0);
    assign z_done     = div_z_stb && div_z_ack;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign fsm_state  = state;

    assign counting = (state == SEND_A) || (state == SEND_B) || (state == WAIT_Z);
    assign cyc_inc  = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_W'(1);

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {job_tag, job_a, job_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are pure state decodes, so reset clears them with the state.
    always_comb begin
        state_next = state;
        div_a_stb  = 1'b0;
        div_b_stb  = 1'b0;
        div_z_ack  = 1'b0;
        res_stb    = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = SEND_A;
                end
            end
            SEND_A: begin
                div_a_stb = 1'b1;
                if (div_a_ack) begin
                    state_next = SEND_B;
                end
            end
            SEND_B: begin
                div_b_stb = 1'b1;
                if (div_b_ack) begin
                    state_next = WAIT_Z;
                end
            end
            WAIT_Z: begin
                div_z_ack = 1'b1;
                if (div_z_stb) begin
                    state_next = PUT_RES;
                end
            end
            PUT_RES: begin
                res_stb = 1'b1;
                if (res_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The capture cycle itself is counted, hence cyc_inc rather than cyc_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_a      <= '0;
            div_b      <= '0;
            tag_q      <= '0;
            cyc_q      <= '0;
            res_z      <= '0;
            res_tag    <= '0;
            res_cycles <= '0;
        end else begin
            if (pop) begin
                {tag_q, div_a, div_b} <= head;
                cyc_q                 <= '0;
            end else if (counting) begin
                cyc_q <= cyc_inc;
            end
            if (z_done) begin
                res_z      <= div_z;
                res_tag    <= tag_q;
                res_cycles <= cyc_inc;
            end
        end
    end

endmodule

// File: tb/tb_div_job_dispatcher.sv
// Bench for div_job_dispatcher: two DUTs (CYC_W=16 and CYC_W=4), each driving a
// behavioural divider model whose z is a ^ rotate16(b) after a programmable latency.
module tb_div_job_dispatcher;

    localparam int TAG_W = 4;
    localparam int E_W   = 1 + 16 + TAG_W + 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [31:0]      job_a, job_b;
    logic [TAG_W-1:0] job_tag;
    logic             job_stb, job_ack;
    logic [31:0]      res_z;
    logic [TAG_W-1:0] res_tag;
    logic [15:0]      res_cycles;
    logic             res_stb, res_ack;
    logic [2:0]       fifo_count, fsm_state;

    logic [31:0]      s_job_a, s_job_b;
    logic [TAG_W-1:0] s_job_tag;
    logic             s_job_stb, s_job_ack;
    logic [31:0]      s_res_z;
    logic [TAG_W-1:0] s_res_tag;
    logic [3:0]       s_res_cycles;
    logic             s_res_stb, s_res_ack;
    logic [2:0]       s_fifo_count, s_fsm_state;

    logic [1:0][31:0] d_a, d_b, d_z;
    logic [1:0]       d_a_stb, d_a_ack, d_b_stb, d_b_ack, d_z_stb, d_z_ack;

    div_job_dispatcher #(.DEPTH(4), .TAG_W(TAG_W), .CYC_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .job_a(job_a), .job_b(job_b), .job_tag(job_tag), .job_stb(job_stb), .job_ack(job_ack),
        .div_a(d_a[0]), .div_a_stb(d_a_stb[0]), .div_a_ack(d_a_ack[0]),
        .div_b(d_b[0]), .div_b_stb(d_b_stb[0]), .div_b_ack(d_b_ack[0]),
        .div_z(d_z[0]), .div_z_stb(d_z_stb[0]), .div_z_ack(d_z_ack[0]),
        .res_z(res_z), .res_tag(res_tag), .res_cycles(res_cycles),
        .res_stb(res_stb), .res_ack(res_ack),
        .fifo_count(fifo_count), .fsm_state(fsm_state)
    );

    div_job_dispatcher #(.DEPTH(4), .TAG_W(TAG_W), .CYC_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .job_a(s_job_a), .job_b(s_job_b), .job_tag(s_job_tag), .job_stb(s_job_stb), .job_ack(s_job_ack),
        .div_a(d_a[1]), .div_a_stb(d_a_stb[1]), .div_a_ack(d_a_ack[1]),
        .div_b(d_b[1]), .div_b_stb(d_b_stb[1]), .div_b_ack(d_b_ack[1]),
        .div_z(d_z[1]), .div_z_stb(d_z_stb[1]), .div_z_ack(d_z_ack[1]),
        .res_z(s_res_z), .res_tag(s_res_tag), .res_cycles(s_res_cycles),
        .res_stb(s_res_stb), .res_ack(s_res_ack),
        .fifo_count(s_fifo_count), .fsm_state(s_fsm_state)
    );

    // Divider model: 0 wait a, 1 wait b, 2 computing, 3 presenting z.
    logic [1:0][1:0]  m_st;
    logic [1:0][31:0] m_a;
    logic [1:0][31:0] m_z;
    logic [1:0]       m_stall;
    int               m_cnt [2];
    int               m_lat [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            d_a_ack[i] = (m_st[i] == 2'd0) && !m_stall[i];
            d_b_ack[i] = (m_st[i] == 2'd1);
            d_z_stb[i] = (m_st[i] == 2'd3);
        end
    end
    assign d_z = m_z;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_st[i]  <= 2'd0;
                m_cnt[i] <= 0;
                m_z[i]   <= 32'd0;
            end else begin
                case (m_st[i])
                    2'd0: if (d_a_stb[i] && d_a_ack[i]) begin
                        m_a[i]  <= d_a[i];
                        m_st[i] <= 2'd1;
                    end
                    2'd1: if (d_b_stb[i] && d_b_ack[i]) begin
                        m_z[i]   <= m_a[i] ^ {d_b[i][15:0], d_b[i][31:16]};
                        m_cnt[i] <= m_lat[i];
                        m_st[i]  <= 2'd2;
                    end
                    2'd2: begin
                        m_cnt[i] <= m_cnt[i] - 1;
                        if (m_cnt[i] == 1) m_st[i] <= 2'd3;
                    end
                    default: if (d_z_stb[i] && d_z_ack[i]) m_st[i] <= 2'd0;
                endcase
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [E_W-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each accepted result is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && res_stb && res_ack) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got tag %h z %h expected none", res_tag, res_z);
            end else begin
                logic [E_W-1:0] e;
                e = exp_q.pop_front();
                check("res_z", {32'd0, res_z}, {32'd0, e[31:0]});
                check("res_tag", {60'd0, res_tag}, {60'd0, e[35:32]});
                if (e[52]) check("res_cycles", {48'd0, res_cycles}, {48'd0, e[51:36]});
            end
        end
    end

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      z;
    } vec_t;
    vec_t vecs [10];

    task automatic push_job(input vec_t v, input logic chk, input logic [15:0] cyc);
        job_a   = v.a;
        job_b   = v.b;
        job_tag = v.tag;
        job_stb = 1'b1;
        for (int k = 0; k < 300 && !job_ack; k++) tick();
        check("push_ready", {63'd0, job_ack}, 64'd1);
        if (job_ack) begin
            tick();
            exp_q.push_back({chk, cyc, v.tag, v.z});
        end
        job_stb = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) tick();
        check(name, 64'(exp_q.size()), 64'd0);
        check({name, "_idle"}, {58'd0, fsm_state, fifo_count}, 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        vecs[0] = '{32'h40C00000, 32'h40400000, 4'd5,  32'h40C04040};
        vecs[1] = '{32'h7FC00000, 32'h3F800000, 4'd1,  32'h7FC03F80};
        vecs[2] = '{32'h7F800000, 32'h00000000, 4'd2,  32'h7F800000};
        vecs[3] = '{32'h00000001, 32'h80000000, 4'd3,  32'h00008001};
        vecs[4] = '{32'hFFFFFFFF, 32'h0000FFFF, 4'd4,  32'h0000FFFF};
        vecs[5] = '{32'h12345678, 32'h00000000, 4'd6,  32'h12345678};
        vecs[6] = '{32'h3F800000, 32'h3F800000, 4'd7,  32'h3F803F80};
        vecs[7] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 4'd8,  32'hFFFFFFFF};
        vecs[8] = '{32'h0000FFFF, 32'hFFFF0000, 4'd9,  32'h00000000};
        vecs[9] = '{32'h80000000, 32'h80000000, 4'd15, 32'h80008000};

        rst = 1'b1;
        job_a = '0; job_b = '0; job_tag = '0; job_stb = 1'b0; res_ack = 1'b1;
        s_job_a = '0; s_job_b = '0; s_job_tag = '0; s_job_stb = 1'b0; s_res_ack = 1'b0;
        m_stall = 2'b00;
        m_lat[0] = 10;
        m_lat[1] = 10;
        repeat (3) tick();
        check("rst_strobes", {59'd0, job_ack, d_a_stb[0], d_b_stb[0], d_z_ack[0], res_stb}, 64'h10);
        check("rst_state", {58'd0, fsm_state, fifo_count}, 64'd0);
        check("rst_div_ab", {d_a[0], d_b[0]}, 64'd0);
        check("rst_res", {res_z, res_tag, res_cycles}, 64'd0);
        rst = 1'b0;
        tick();

        // Single job: pop latency, operand presentation, result held until accepted.
        res_ack = 1'b0;
        job_a = vecs[0].a; job_b = vecs[0].b; job_tag = vecs[0].tag; job_stb = 1'b1;
        tick();
        job_stb = 1'b0;
        exp_q.push_back({1'b1, 16'd13, vecs[0].tag, vecs[0].z});
        check("t1_queued", {60'd0, d_a_stb[0], fifo_count}, {60'd0, 1'b0, 3'd1});
        tick();
        check("t1_popped", {60'd0, d_a_stb[0], fifo_count}, {60'd0, 1'b1, 3'd0});
        check("t1_div_ab", {d_a[0], d_b[0]}, {vecs[0].a, vecs[0].b});
        for (int k = 0; k < 100 && !res_stb; k++) tick();
        for (int k = 0; k < 5; k++) begin
            check("t1_hold", {27'd0, res_stb, res_tag, res_z}, {27'd0, 1'b1, vecs[0].tag, vecs[0].z});
            tick();
        end
        res_ack = 1'b1;
        tick();
        check("t1_done", {59'd0, res_stb, fifo_count}, 64'd0);
        drain("t1_drain");

        // Back-to-back tags 1,2,3.
        for (int i = 1; i <= 3; i++) push_job(vecs[i], 1'b1, 16'd13);
        drain("t2_drain");

        // Divider stalls on a: one job in flight, four queued, sixth push held off.
        m_stall[0] = 1'b1;
        for (int i = 0; i < 5; i++) push_job(vecs[i], (i != 0), 16'd13);
        check("t3_full", {57'd0, job_ack, fsm_state, fifo_count}, {57'd0, 1'b0, 3'd1, 3'd4});
        job_a = vecs[5].a; job_b = vecs[5].b; job_tag = vecs[5].tag; job_stb = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_blocked", {60'd0, job_ack, fifo_count}, {60'd0, 1'b0, 3'd4});
        end
        m_stall[0] = 1'b0;
        push_job(vecs[5], 1'b1, 16'd13);
        drain("t3_drain");

        // Consumer stalls 20 cycles, then accept coincides with a push at count 2.
        res_ack = 1'b0;
        for (int i = 6; i <= 8; i++) push_job(vecs[i], 1'b1, 16'd13);
        for (int k = 0; k < 100 && !res_stb; k++) tick();
        for (int k = 0; k < 20; k++) begin
            check("t4_hold", {23'd0, res_stb, d_a_stb[0], fifo_count, res_tag, res_z},
                  {23'd0, 1'b1, 1'b0, 3'd2, vecs[6].tag, vecs[6].z});
            tick();
        end
        res_ack = 1'b1;
        tick();
        check("t4_idle2", {58'd0, fsm_state, fifo_count}, {58'd0, 3'd0, 3'd2});
        job_a = vecs[9].a; job_b = vecs[9].b; job_tag = vecs[9].tag; job_stb = 1'b1;
        tick();
        job_stb = 1'b0;
        exp_q.push_back({1'b1, 16'd13, vecs[9].tag, vecs[9].z});
        check("t4_push_pop", {58'd0, fsm_state, fifo_count}, {58'd0, 3'd1, 3'd2});
        drain("t4_drain");

        // Whole table back-to-back; pointers wrap several times.
        for (int i = 0; i < 10; i++) push_job(vecs[i], 1'b1, 16'd13);
        drain("t5_drain");

        // Reset in WAIT_Z with two jobs queued.
        m_lat[0] = 30;
        for (int i = 1; i <= 3; i++) push_job(vecs[i], 1'b1, 16'd33);
        for (int k = 0; k < 50 && !(fsm_state == 3'd3 && fifo_count == 3'd2); k++) tick();
        check("t6_setup", {58'd0, fsm_state, fifo_count}, {58'd0, 3'd3, 3'd2});
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_strobes", {59'd0, job_ack, d_a_stb[0], d_b_stb[0], d_z_ack[0], res_stb}, 64'h10);
        check("t6_state", {58'd0, fsm_state, fifo_count}, 64'd0);
        check("t6_res", {res_z, res_tag, res_cycles}, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            seen = seen | res_stb | (fifo_count != 3'd0);
        end
        check("t6_no_result", {63'd0, seen}, 64'd0);

        // Long latency: 16-bit counter reads 43, 4-bit counter saturates at 15.
        m_lat[0] = 40;
        m_lat[1] = 40;
        s_job_a = vecs[4].a; s_job_b = vecs[4].b; s_job_tag = vecs[4].tag; s_job_stb = 1'b1;
        push_job(vecs[4], 1'b1, 16'd43);
        s_job_stb = 1'b0;
        for (int k = 0; k < 200 && !s_res_stb; k++) tick();
        check("t7_sat_cycles", {60'd0, s_res_cycles}, 64'd15);
        check("t7_sat_res", {27'd0, s_res_stb, s_res_tag, s_res_z}, {27'd0, 1'b1, vecs[4].tag, vecs[4].z});
        s_res_ack = 1'b1;
        tick();
        s_res_ack = 1'b0;
        check("t7_sat_done", {60'd0, s_res_stb, s_fifo_count}, 64'd0);
        drain("t7_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
